// File: rtl/sha256_msg_padder_if.sv
// Stream-in / block-out bundle between a message source, the padder and the SHA-256 core wrapper.
// The slave modport is the padder's side; the master modport is the source/consumer side.
interface sha256_msg_padder_if;
   logic [31:0]  iData;
   logic         iValid;
   logic         iLast;
   logic [2:0]   iLastBytes;
   logic         oReady;
   logic [511:0] oBlock;
   logic         oBlockValid;
   logic         oBlockLast;
   logic         iBlockReady;

   modport slave (
      input  iData, iValid, iLast, iLastBytes, iBlockReady,
      output oReady, oBlock, oBlockValid, oBlockLast
   );

   modport master (
      output iData, iValid, iLast, iLastBytes, iBlockReady,
      input  oReady, oBlock, oBlockValid, oBlockLast
   );
endinterface

// File: rtl/sha256_msg_padder.sv
// FIPS 180-4 message padder: packs 32-bit big-endian words into 512-bit blocks,
// appends 0x80, zero fill and the 64-bit bit length, and hands blocks out over valid/ready.
module sha256_msg_padder #(
   parameter int unsigned MAX_LEN_W = 64
) (
   input  logic                iClk,
   input  logic                iReset,
   sha256_msg_padder_if.slave  bus
);

   typedef enum logic [1:0] {S_FILL, S_PAD, S_LEN, S_OUT} state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic [15:0][31:0]    r_buf;
   logic [4:0]           r_widx;
   logic [MAX_LEN_W-1:0] r_len;
   logic                 r_pad_pending;
   logic                 r_msg_ended;
   logic                 r_last;
   logic                 r_ready;

   logic                 w_accept;
   logic [4:0]           w_widx_inc;
   logic [2:0]           w_nbytes;
   logic [3:0]           w_keep;
   logic [31:0]          w_pad;
   logic [31:0]          w_word;
   logic [MAX_LEN_W-1:0] w_len_add;

   assign w_accept   = r_ready & bus.iValid;
   assign w_widx_inc = r_widx + 5'd1;
   assign w_nbytes   = (bus.iLast && (bus.iLastBytes < 3'd4)) ? bus.iLastBytes : 3'd4;
   assign w_len_add  = MAX_LEN_W'({w_nbytes, 3'b000});

   // Non-last words always carry 4 bytes, so the 0x80 marker only lands on a short last word.
   always_comb begin
      w_keep = 4'b1111;
      w_pad  = '0;
      case (w_nbytes)
         3'd0: begin w_keep = 4'b0000; w_pad = 32'h8000_0000; end
         3'd1: begin w_keep = 4'b1000; w_pad = 32'h0080_0000; end
         3'd2: begin w_keep = 4'b1100; w_pad = 32'h0000_8000; end
         3'd3: begin w_keep = 4'b1110; w_pad = 32'h0000_0080; end
         default: begin w_keep = 4'b1111; w_pad = '0; end
      endcase
      w_word = (bus.iData & {{8{w_keep[3]}}, {8{w_keep[2]}}, {8{w_keep[1]}}, {8{w_keep[0]}}}) | w_pad;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_FILL: begin
            if (w_accept) begin
               if (bus.iLast) begin
                  if (w_nbytes != 3'd4)        w_state_next = S_LEN;
                  else if (w_widx_inc < 5'd16) w_state_next = S_PAD;
                  else                         w_state_next = S_OUT;
               end else if (w_widx_inc == 5'd16) begin
                  w_state_next = S_OUT;
               end
            end
         end
         S_PAD: w_state_next = S_LEN;
         S_LEN: w_state_next = S_OUT;
         S_OUT: begin
            if (bus.iBlockReady) begin
               if (r_last)             w_state_next = S_FILL;
               else if (r_pad_pending) w_state_next = S_PAD;
               else if (r_msg_ended)   w_state_next = S_LEN;
               else                    w_state_next = S_FILL;
            end
         end
         default: w_state_next = S_FILL;
      endcase
   end

   // oReady is registered so it stays low for the whole reset cycle and rises one cycle later.
   always_ff @(posedge iClk) begin
      if (iReset) begin
         r_state <= S_FILL;
         r_ready <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_ready <= (w_state_next == S_FILL);
      end
   end

   always_ff @(posedge iClk) begin
      if (iReset) begin
         r_buf         <= '0;
         r_widx        <= '0;
         r_len         <= '0;
         r_pad_pending <= 1'b0;
         r_msg_ended   <= 1'b0;
         r_last        <= 1'b0;
      end else begin
         case (r_state)
            S_FILL: begin
               if (w_accept) begin
                  r_buf[r_widx[3:0]] <= w_word;
                  r_widx             <= w_widx_inc;
                  r_len              <= r_len + w_len_add;
                  if (bus.iLast) begin
                     r_msg_ended   <= 1'b1;
                     r_pad_pending <= (w_nbytes == 3'd4);
                  end
               end
            end
            S_PAD: begin
               r_buf[r_widx[3:0]] <= 32'h8000_0000;
               r_widx             <= w_widx_inc;
               r_pad_pending      <= 1'b0;
            end
            S_LEN: begin
               // Length needs words 14 and 15 free; otherwise it spills into a fresh block.
               if (r_widx <= 5'd14) begin
                  r_buf[14] <= r_len[63:32];
                  r_buf[15] <= r_len[31:0];
                  r_last    <= 1'b1;
               end
            end
            S_OUT: begin
               if (bus.iBlockReady) begin
                  r_buf  <= '0;
                  r_widx <= '0;
                  r_last <= 1'b0;
                  if (r_last) begin
                     r_len       <= '0;
                     r_msg_ended <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.oReady      = r_ready;
   assign bus.oBlock      = r_buf;
   assign bus.oBlockValid = (r_state == S_OUT);
   assign bus.oBlockLast  = r_last;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed self-checking bench for sha256_msg_padder: known messages with hand-computed padded blocks.
module tb_sha256_msg_padder;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   sha256_msg_padder_if bus ();

   sha256_msg_padder #(.MAX_LEN_W(64)) dut (
      .iClk   (clk),
      .iReset (rst),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Offer one word from a negedge; returns at the negedge after the accepting edge.
   task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] lb, output bit ok);
      ok = 1'b0;
      bus.iData      = d;
      bus.iValid     = 1'b1;
      bus.iLast      = last;
      bus.iLastBytes = lb;
      for (int i = 0; i < 50; i++) begin
         if (bus.oReady) begin
            ok = 1'b1;
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
      bus.iValid = 1'b0;
      bus.iLast  = 1'b0;
   endtask

   task automatic wait_block(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (bus.oBlockValid) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic accept_block();
      bus.iBlockReady = 1'b1;
      @(negedge clk);
      bus.iBlockReady = 1'b0;
   endtask

   function automatic logic [511:0] abc_block();
      logic [511:0] b;
      b = '0;
      b[31:0]    = 32'h6162_6380;
      b[511:480] = 32'h0000_0018;
      return b;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (bus.oReady !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", bus.oReady); end
      checks++;
      if (bus.oBlockValid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.oBlockValid); end
      checks++;
      if (bus.oBlockLast !== 1'b0) begin failures++; $display("FAIL reset_last got=%b exp=0", bus.oBlockLast); end
      checks++;
      if (bus.oBlock !== 512'd0) begin failures++; $display("FAIL reset_block got=%h exp=0", bus.oBlock); end
      rst = 1'b0;
      checks++;
      if (bus.oReady !== 1'b0) begin failures++; $display("FAIL reset_ready_hold got=%b exp=0", bus.oReady); end
      @(negedge clk);
      checks++;
      if (bus.oReady !== 1'b1) begin failures++; $display("FAIL reset_ready_rise got=%b exp=1", bus.oReady); end
   endtask

   task automatic test_abc();
      bit ok;
      send_word(32'h6162_6300, 1'b1, 3'd3, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL abc_accept got=timeout exp=accepted"); end
      checks++;
      if (bus.oBlockValid !== 1'b0) begin failures++; $display("FAIL abc_valid_early got=%b exp=0", bus.oBlockValid); end
      @(negedge clk);
      checks++;
      if (bus.oBlockValid !== 1'b1) begin failures++; $display("FAIL abc_valid_latency got=%b exp=1", bus.oBlockValid); end
      checks++;
      if (bus.oBlockLast !== 1'b1) begin failures++; $display("FAIL abc_last got=%b exp=1", bus.oBlockLast); end
      checks++;
      if (bus.oBlock !== abc_block()) begin failures++; $display("FAIL abc_block got=%h exp=%h", bus.oBlock, abc_block()); end
      accept_block();
      checks++;
      if (bus.oBlockValid !== 1'b0 || bus.oReady !== 1'b1) begin
         failures++; $display("FAIL abc_release got=valid%b/ready%b exp=valid0/ready1", bus.oBlockValid, bus.oReady);
      end
   endtask

   task automatic test_empty();
      bit ok;
      logic [511:0] exp;
      exp = '0;
      exp[31:0] = 32'h8000_0000;
      send_word(32'hFFFF_FFFF, 1'b1, 3'd0, ok);
      wait_block(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL empty_wait got=timeout exp=block"); end
      checks++;
      if (bus.oBlock !== exp || bus.oBlockLast !== 1'b1) begin
         failures++; $display("FAIL empty_block got=%h last=%b exp=%h last=1", bus.oBlock, bus.oBlockLast, exp);
      end
      accept_block();
   endtask

   task automatic test_lastbytes_clamp();
      bit ok;
      logic [511:0] exp;
      exp = '0;
      exp[31:0]    = 32'h6162_6364;
      exp[63:32]   = 32'h8000_0000;
      exp[511:480] = 32'h0000_0020;
      send_word(32'h6162_6364, 1'b1, 3'd7, ok);
      wait_block(ok);
      checks++;
      if (!ok || bus.oBlock !== exp || bus.oBlockLast !== 1'b1) begin
         failures++; $display("FAIL clamp_block got=%h last=%b exp=%h last=1", bus.oBlock, bus.oBlockLast, exp);
      end
      accept_block();
   endtask

   task automatic test_14_words();
      bit ok;
      bit all_ok;
      logic [511:0] exp;
      all_ok = 1'b1;
      for (int i = 0; i < 14; i++) begin
         send_word(32'h0101_0101, (i == 13), 3'd4, ok);
         all_ok &= ok;
      end
      checks++;
      if (!all_ok) begin failures++; $display("FAIL w14_accept got=timeout exp=accepted"); end
      exp = '0;
      for (int k = 0; k < 14; k++) exp[32*k +: 32] = 32'h0101_0101;
      exp[479:448] = 32'h8000_0000;
      wait_block(ok);
      checks++;
      if (!ok || bus.oBlock !== exp || bus.oBlockLast !== 1'b0) begin
         failures++; $display("FAIL w14_block1 got=%h last=%b exp=%h last=0", bus.oBlock, bus.oBlockLast, exp);
      end
      accept_block();
      exp = '0;
      exp[511:480] = 32'h0000_01C0;
      wait_block(ok);
      checks++;
      if (!ok || bus.oBlock !== exp || bus.oBlockLast !== 1'b1) begin
         failures++; $display("FAIL w14_block2 got=%h last=%b exp=%h last=1", bus.oBlock, bus.oBlockLast, exp);
      end
      accept_block();
   endtask

   task automatic test_16_words();
      bit ok;
      bit all_ok;
      logic [511:0] exp;
      all_ok = 1'b1;
      for (int i = 0; i < 16; i++) begin
         send_word(32'h0101_0101, (i == 15), 3'd4, ok);
         all_ok &= ok;
      end
      checks++;
      if (!all_ok) begin failures++; $display("FAIL w16_accept got=timeout exp=accepted"); end
      exp = '0;
      for (int k = 0; k < 16; k++) exp[32*k +: 32] = 32'h0101_0101;
      wait_block(ok);
      checks++;
      if (!ok || bus.oBlock !== exp || bus.oBlockLast !== 1'b0) begin
         failures++; $display("FAIL w16_block1 got=%h last=%b exp=%h last=0", bus.oBlock, bus.oBlockLast, exp);
      end
      accept_block();
      exp = '0;
      exp[31:0]    = 32'h8000_0000;
      exp[511:480] = 32'h0000_0200;
      wait_block(ok);
      checks++;
      if (!ok || bus.oBlock !== exp || bus.oBlockLast !== 1'b1) begin
         failures++; $display("FAIL w16_block2 got=%h last=%b exp=%h last=1", bus.oBlock, bus.oBlockLast, exp);
      end
      checks++;
      if (bus.oReady !== 1'b0) begin failures++; $display("FAIL w16_ready_pending got=%b exp=0", bus.oReady); end
      accept_block();
      checks++;
      if (bus.oReady !== 1'b1) begin failures++; $display("FAIL w16_ready_after got=%b exp=1", bus.oReady); end
   endtask

   task automatic test_backpressure();
      bit ok;
      send_word(32'h6162_6300, 1'b1, 3'd3, ok);
      wait_block(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL bp_wait got=timeout exp=block"); end
      for (int c = 0; c < 5; c++) begin
         bus.iData      = 32'hDEAD_BEEF;
         bus.iValid     = 1'b1;
         bus.iLast      = 1'b1;
         bus.iLastBytes = 3'd4;
         checks++;
         if (bus.oBlockValid !== 1'b1 || bus.oReady !== 1'b0 || bus.oBlock !== abc_block()) begin
            failures++;
            $display("FAIL bp_stall%0d got=valid%b/ready%b/%h exp=valid1/ready0/%h",
                     c, bus.oBlockValid, bus.oReady, bus.oBlock, abc_block());
         end
         @(negedge clk);
      end
      bus.iValid = 1'b0;
      bus.iLast  = 1'b0;
      accept_block();
      checks++;
      if (bus.oBlockValid !== 1'b0 || bus.oReady !== 1'b1) begin
         failures++; $display("FAIL bp_release got=valid%b/ready%b exp=valid0/ready1", bus.oBlockValid, bus.oReady);
      end
      // A word absorbed during the stall would change both data and length of this block.
      send_word(32'h6162_6300, 1'b1, 3'd3, ok);
      wait_block(ok);
      checks++;
      if (!ok || bus.oBlock !== abc_block()) begin
         failures++; $display("FAIL bp_next got=%h exp=%h", bus.oBlock, abc_block());
      end
      accept_block();
   endtask

   task automatic test_reset_mid();
      bit ok;
      for (int i = 0; i < 7; i++) send_word(32'hA5A5_0000 + 32'(i), 1'b0, 3'd4, ok);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.oReady !== 1'b0 || bus.oBlockValid !== 1'b0 || bus.oBlockLast !== 1'b0 || bus.oBlock !== 512'd0) begin
         failures++;
         $display("FAIL rst_fill got=ready%b/valid%b/last%b/%h exp=all0",
                  bus.oReady, bus.oBlockValid, bus.oBlockLast, bus.oBlock);
      end
      rst = 1'b0;
      send_word(32'h6162_6300, 1'b1, 3'd3, ok);
      wait_block(ok);
      checks++;
      if (!ok || bus.oBlock !== abc_block() || bus.oBlockLast !== 1'b1) begin
         failures++; $display("FAIL rst_fill_abc got=%h exp=%h", bus.oBlock, abc_block());
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.oReady !== 1'b0 || bus.oBlockValid !== 1'b0 || bus.oBlockLast !== 1'b0 || bus.oBlock !== 512'd0) begin
         failures++;
         $display("FAIL rst_out got=ready%b/valid%b/last%b/%h exp=all0",
                  bus.oReady, bus.oBlockValid, bus.oBlockLast, bus.oBlock);
      end
      rst = 1'b0;
      send_word(32'h6162_6300, 1'b1, 3'd3, ok);
      wait_block(ok);
      checks++;
      if (!ok || bus.oBlock !== abc_block() || bus.oBlockLast !== 1'b1) begin
         failures++; $display("FAIL rst_out_abc got=%h exp=%h", bus.oBlock, abc_block());
      end
      accept_block();
   endtask

   initial begin
      checks          = 0;
      failures        = 0;
      rst             = 1'b1;
      bus.iData       = '0;
      bus.iValid      = 1'b0;
      bus.iLast       = 1'b0;
      bus.iLastBytes  = 3'd0;
      bus.iBlockReady = 1'b0;
      @(negedge clk);
      test_reset();
      test_abc();
      test_empty();
      test_lastbytes_clamp();
      test_14_words();
      test_16_words();
      test_backpressure();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
